// File: rtl/mac_vlg_pkg.sv
// Shared constants and types for the MAC receive/transmit datapath.
package mac_vlg_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam int          HDR_LEN       = 14;
  localparam int          FCS_LEN       = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_PREAMBLE,
    RX_HEADER,
    RX_PAYLOAD,
    RX_DROP
  } rx_fsm_t;

  // First received header byte ends up in the MSBs of dst.
  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] ethertype;
  } mac_hdr_t;

  // Bit-reverse a 32-bit word; the LSB-first CRC uses the mirrored polynomial.
  function automatic logic [31:0] reflect32(input logic [31:0] value);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      result[i] = value[31 - i];
    end
    return result;
  endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// No final inversion is applied, so the register form can be compared
// directly against the receive residue or inverted by a transmitter.
module crc32_byte
  import mac_vlg_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFLECTED = reflect32(CRC_POLY);

  logic [31:0] crc_work;

  // Fold the byte into the low bits, then shift out eight bits LSB first.
  always_comb begin
    crc_work = crc_in ^ {24'h000000, data_in};
    for (int i = 0; i < 8; i++) begin
      if (crc_work[0]) begin
        crc_work = (crc_work >> 1) ^ POLY_REFLECTED;
      end else begin
        crc_work = crc_work >> 1;
      end
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/mac_vlg_rx.sv
// MAC receive parser: strips preamble/SFD, captures the 14-byte header,
// checks the FCS and forwards only the payload bytes with frame status.
// The last four bytes of every frame are the FCS; they are held in a
// four-byte delay line so they are never forwarded, and a fifth register
// holds the byte that becomes the last payload byte when valid_in drops.
module mac_vlg_rx
  import mac_vlg_pkg::*;
#(
  parameter int PRE_MIN   = 5,
  parameter int MTU       = 1500,
  parameter int MIN_FRAME = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  input  logic        error_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        sof_out,
  output logic        eof_out,
  output logic        error_out,
  output logic        fcs_ok,
  output logic [15:0] len_out,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] ethertype,
  output logic        hdr_valid
);

  localparam logic [3:0] HDR_LAST  = 4'(HDR_LEN - 1);
  localparam logic [2:0] FILL_FULL = 3'(FCS_LEN + 1);
  localparam logic [2:0] PRE_SAT   = 3'd7;
  localparam int         HDR_BITS  = $bits(mac_hdr_t);

  rx_fsm_t          state_q, state_d;
  logic [2:0]       pre_cnt_q, pre_cnt_d;
  logic [3:0]       hdr_cnt_q, hdr_cnt_d;
  logic [31:0]      crc_q, crc_d;
  logic [31:0]      crc_next;
  mac_hdr_t         hdr_q, hdr_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic [3:0][7:0]  dl_q, dl_d;
  logic [7:0]       out_byte_q, out_byte_d;
  logic [2:0]       fill_q, fill_d;
  logic             first_q, first_d;
  logic [15:0]      pay_cnt_q, pay_cnt_d;
  logic             err_q, err_d;

  logic             pre_ok;
  logic             emit;
  logic [15:0]      frame_len;
  logic             crc_pass;
  logic             runt;
  logic             oversize;

  crc32_byte u_crc (
    .crc_in  (crc_q),
    .data_in (data_in),
    .crc_out (crc_next)
  );

  assign pre_ok = (int'({29'd0, pre_cnt_q}) >= PRE_MIN);

  // The held byte is a confirmed payload byte once the delay line behind it is full.
  assign emit = (state_q == RX_PAYLOAD) && (fill_q == FILL_FULL);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      pre_cnt_q   <= '0;
      hdr_cnt_q   <= '0;
      crc_q       <= '0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      dl_q        <= '0;
      out_byte_q  <= '0;
      fill_q      <= '0;
      first_q     <= 1'b0;
      pay_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      hdr_cnt_q   <= hdr_cnt_d;
      crc_q       <= crc_d;
      hdr_q       <= hdr_d;
      hdr_valid_q <= hdr_valid_d;
      dl_q        <= dl_d;
      out_byte_q  <= out_byte_d;
      fill_q      <= fill_d;
      first_q     <= first_d;
      pay_cnt_q   <= pay_cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic; any loss of valid_in ends the frame and returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE: begin
        if (valid_in) begin
          state_d = (data_in == PREAMBLE_BYTE) ? RX_PREAMBLE : RX_DROP;
        end
      end
      RX_PREAMBLE: begin
        if (!valid_in) begin
          state_d = RX_IDLE;
        end else if (data_in == PREAMBLE_BYTE) begin
          state_d = RX_PREAMBLE;
        end else if ((data_in == SFD_BYTE) && pre_ok) begin
          state_d = RX_HEADER;
        end else begin
          state_d = RX_DROP;
        end
      end
      RX_HEADER: begin
        if (!valid_in) begin
          state_d = RX_IDLE;
        end else if (hdr_cnt_q == HDR_LAST) begin
          state_d = RX_PAYLOAD;
        end
      end
      RX_PAYLOAD: begin
        if (!valid_in) begin
          state_d = RX_IDLE;
        end
      end
      RX_DROP: begin
        if (!valid_in) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Datapath updates: preamble count, header shift-in, CRC, delay line and counters.
  always_comb begin
    pre_cnt_d   = pre_cnt_q;
    hdr_cnt_d   = hdr_cnt_q;
    crc_d       = crc_q;
    hdr_d       = hdr_q;
    hdr_valid_d = 1'b0;
    dl_d        = dl_q;
    out_byte_d  = out_byte_q;
    fill_d      = fill_q;
    first_d     = first_q;
    pay_cnt_d   = pay_cnt_q;
    err_d       = err_q;
    unique case (state_q)
      RX_IDLE: begin
        if (valid_in && (data_in == PREAMBLE_BYTE)) begin
          pre_cnt_d = 3'd1;
          err_d     = error_in;
        end
      end
      RX_PREAMBLE: begin
        if (valid_in) begin
          err_d = err_q | error_in;
          if (data_in == PREAMBLE_BYTE) begin
            pre_cnt_d = (pre_cnt_q == PRE_SAT) ? PRE_SAT : pre_cnt_q + 3'd1;
          end else if ((data_in == SFD_BYTE) && pre_ok) begin
            crc_d     = CRC_INIT;
            hdr_cnt_d = '0;
          end
        end
      end
      RX_HEADER: begin
        if (valid_in) begin
          err_d     = err_q | error_in;
          crc_d     = crc_next;
          hdr_d     = {hdr_q[HDR_BITS-9:0], data_in};
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          if (hdr_cnt_q == HDR_LAST) begin
            hdr_valid_d = 1'b1;
            fill_d      = '0;
            first_d     = 1'b1;
            pay_cnt_d   = '0;
          end
        end
      end
      RX_PAYLOAD: begin
        if (valid_in) begin
          err_d      = err_q | error_in;
          crc_d      = crc_next;
          dl_d       = {dl_q[2:0], data_in};
          out_byte_d = dl_q[3];
          fill_d     = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 3'd1;
          if (emit) begin
            first_d   = 1'b0;
            pay_cnt_d = (pay_cnt_q == 16'hFFFF) ? 16'hFFFF : pay_cnt_q + 16'd1;
          end
        end else begin
          first_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // Frame status: the eof byte itself is counted on top of the bytes already emitted.
  always_comb begin
    frame_len = (pay_cnt_q == 16'hFFFF) ? 16'hFFFF : pay_cnt_q + 16'd1;
    crc_pass  = (crc_q == CRC_RESIDUE);
    runt      = (int'({16'd0, frame_len}) + HDR_LEN + FCS_LEN) < MIN_FRAME;
    oversize  = int'({16'd0, frame_len}) > MTU;
  end

  // Output decode: payload strobes follow valid_in so eof lands in the first idle cycle.
  always_comb begin
    data_out  = out_byte_q;
    valid_out = emit;
    sof_out   = emit && first_q;
    eof_out   = emit && !valid_in;
    fcs_ok    = emit && !valid_in && crc_pass;
    error_out = emit && !valid_in && (!crc_pass || err_q || runt || oversize);
    len_out   = (emit && !valid_in) ? frame_len : 16'h0000;
    hdr_valid = hdr_valid_q;
    dst_mac   = hdr_q.dst;
    src_mac   = hdr_q.src;
    ethertype = hdr_q.ethertype;
  end

endmodule

// File: tb/tb_mac_vlg_rx.sv
// Self-checking bench for mac_vlg_rx: frames are assembled from a payload
// and header, the FCS comes from a bit-serial CRC model, and the expected
// payload stream and frame status come from the frame-level rules.
module tb_mac_vlg_rx;

  localparam int PRE_MIN   = 5;
  localparam int MTU       = 1500;
  localparam int MIN_FRAME = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        valid_in = 1'b0;
  logic        error_in = 1'b0;
  logic [7:0]  data_out;
  logic        valid_out, sof_out, eof_out, error_out, fcs_ok, hdr_valid;
  logic [15:0] len_out, ethertype;
  logic [47:0] dst_mac, src_mac;

  int checks = 0;
  int errors = 0;

  logic [47:0]  exp_dst, exp_src;
  logic [15:0]  exp_eth;
  byte unsigned tx_pay[$];
  byte unsigned wire_q[$];
  byte unsigned exp_all[$];

  byte unsigned got_q[$];
  int           sof_at_q[$];
  int           eof_at_q[$];
  int           eof_len_q[$];
  bit           eof_err_q[$];
  bit           eof_fcs_q[$];
  int           hdr_cnt;

  mac_vlg_rx #(.PRE_MIN(PRE_MIN), .MTU(MTU), .MIN_FRAME(MIN_FRAME)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in), .error_in(error_in),
    .data_out(data_out), .valid_out(valid_out), .sof_out(sof_out), .eof_out(eof_out),
    .error_out(error_out), .fcs_ok(fcs_ok), .len_out(len_out), .dst_mac(dst_mac),
    .src_mac(src_mac), .ethertype(ethertype), .hdr_valid(hdr_valid)
  );

  always #5 clk = ~clk;

  // Record everything the DUT emits, sampled away from the rising edge.
  always @(negedge clk) begin
    if (hdr_valid) hdr_cnt++;
    if (valid_out) begin
      if (sof_out) sof_at_q.push_back(got_q.size());
      got_q.push_back(data_out);
    end
    if (eof_out) begin
      eof_at_q.push_back(got_q.size());
      eof_len_q.push_back(int'(len_out));
      eof_err_q.push_back(error_out);
      eof_fcs_q.push_back(fcs_ok);
    end
  end

  task automatic clear_mon();
    got_q.delete(); sof_at_q.delete(); eof_at_q.delete(); eof_len_q.delete();
    eof_err_q.delete(); eof_fcs_q.delete(); exp_all.delete(); hdr_cnt = 0;
  endtask

  // Bit-serial LSB-first CRC-32 register (no final inversion).
  function automatic logic [31:0] crc32_ref(input byte unsigned q[$]);
    logic [31:0] crc = 32'hFFFFFFFF;
    logic fb;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb  = crc[0] ^ q[i][b];
        crc = crc >> 1;
        if (fb) crc = crc ^ 32'hEDB88320;
      end
    end
    return crc;
  endfunction

  function automatic int count_diffs();
    int d = 0;
    for (int i = 0; i < got_q.size() && i < exp_all.size(); i++)
      if (got_q[i] != exp_all[i]) d++;
    return d;
  endfunction

  task automatic rand_hdr();
    exp_dst = {16'($urandom), 32'($urandom)};
    exp_src = {16'($urandom), 32'($urandom)};
    exp_eth = 16'($urandom);
  endtask

  task automatic rand_payload(input int len);
    tx_pay.delete();
    for (int k = 0; k < len; k++) tx_pay.push_back(8'($urandom));
  endtask

  // Build preamble + SFD + header + payload + good FCS, then optionally flip one payload bit.
  task automatic build_frame(input int n_pre, input int flip_bit);
    byte unsigned body[$];
    logic [31:0] fcs;
    wire_q.delete();
    for (int i = 0; i < 6; i++) body.push_back(exp_dst[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(exp_src[47 - 8*i -: 8]);
    body.push_back(exp_eth[15:8]);
    body.push_back(exp_eth[7:0]);
    foreach (tx_pay[k]) body.push_back(tx_pay[k]);
    fcs = ~crc32_ref(body);
    for (int i = 0; i < 4; i++) body.push_back(fcs[8*i +: 8]);
    if (flip_bit >= 0) begin
      body[14 + flip_bit/8] = body[14 + flip_bit/8] ^ 8'(1 << (flip_bit % 8));
      tx_pay[flip_bit/8]    = tx_pay[flip_bit/8] ^ 8'(1 << (flip_bit % 8));
    end
    for (int i = 0; i < n_pre; i++) wire_q.push_back(8'h55);
    wire_q.push_back(8'hD5);
    foreach (body[i]) wire_q.push_back(body[i]);
    foreach (tx_pay[k]) exp_all.push_back(tx_pay[k]);
  endtask

  // Drive the assembled frame gap-free, then drop valid_in for one cycle.
  task automatic drive_bytes(input int err_pos);
    for (int i = 0; i < wire_q.size(); i++) begin
      @(posedge clk); #1;
      data_in = wire_q[i]; valid_in = 1'b1; error_in = (i == err_pos);
    end
    @(posedge clk); #1;
    data_in = 8'h00; valid_in = 1'b0; error_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    checks++;
    if ({valid_out, sof_out, eof_out, error_out, fcs_ok, hdr_valid} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_strobes: got %b want 000000", {valid_out, sof_out, eof_out, error_out, fcs_ok, hdr_valid});
    end
    checks++;
    if (len_out !== 16'h0 || data_out !== 8'h0) begin
      errors++; $display("[TB] FAIL reset_len_data: got %h/%h want 0/0", len_out, data_out);
    end
    checks++;
    if (dst_mac !== 48'h0 || src_mac !== 48'h0 || ethertype !== 16'h0) begin
      errors++; $display("[TB] FAIL reset_hdr: got %h %h %h want 0", dst_mac, src_mac, ethertype);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    clear_mon();
    rand_hdr();
    tx_pay.delete();
    for (int k = 0; k < 46; k++) tx_pay.push_back(8'(k));
    build_frame(7, -1);
    drive_bytes(-1);
    idle(3);
    checks++;
    if (hdr_cnt !== 1) begin errors++; $display("[TB] FAIL good_hdr_valid: got %0d want 1", hdr_cnt); end
    checks++;
    if ({dst_mac, src_mac, ethertype} !== {exp_dst, exp_src, exp_eth}) begin
      errors++; $display("[TB] FAIL good_hdr_fields: got %h %h %h want %h %h %h", dst_mac, src_mac, ethertype, exp_dst, exp_src, exp_eth);
    end
    checks++;
    if (got_q.size() !== 46) begin errors++; $display("[TB] FAIL good_count: got %0d want 46", got_q.size()); end
    checks++;
    if (count_diffs() !== 0) begin errors++; $display("[TB] FAIL good_bytes: got %0d diffs want 0", count_diffs()); end
    checks++;
    if (sof_at_q.size() !== 1 || (sof_at_q.size() == 1 && got_q[sof_at_q[0]] !== 8'h00)) begin
      errors++; $display("[TB] FAIL good_sof: got %0d sof pulses want 1 on byte 00", sof_at_q.size());
    end
    checks++;
    if (eof_at_q.size() !== 1) begin
      errors++; $display("[TB] FAIL good_eof_count: got %0d want 1", eof_at_q.size());
    end else begin
      checks++;
      if (got_q[eof_at_q[0] - 1] !== 8'h2D) begin
        errors++; $display("[TB] FAIL good_eof_byte: got %h want 2d", got_q[eof_at_q[0] - 1]);
      end
      checks++;
      if ({eof_len_q[0], eof_err_q[0], eof_fcs_q[0]} !== {32'd46, 1'b0, 1'b1}) begin
        errors++; $display("[TB] FAIL good_status: got len %0d err %0d fcs %0d want 46 0 1", eof_len_q[0], eof_err_q[0], eof_fcs_q[0]);
      end
    end
  endtask

  // Single frames exercising FCS, error_in, runt, oversize and tiny payloads.
  task automatic run_model_frame(input string name, input int len, input int n_pre, input bit flip, input int err_k);
    int flip_bit;
    bit exp_err;
    int exp_eof;
    clear_mon();
    rand_hdr();
    rand_payload(len);
    flip_bit = (flip && len > 0) ? int'($urandom_range(len*8 - 1)) : -1;
    build_frame(n_pre, flip_bit);
    drive_bytes((err_k >= 0) ? n_pre + 15 + err_k : -1);
    idle(3);
    exp_err = (flip_bit >= 0) || (err_k >= 0) || (18 + len < MIN_FRAME) || (len > MTU);
    exp_eof = (len > 0) ? 1 : 0;
    checks++;
    if (hdr_cnt !== 1 || {dst_mac, src_mac, ethertype} !== {exp_dst, exp_src, exp_eth}) begin
      errors++; $display("[TB] FAIL %s hdr: got %0d pulses dst %h want 1 dst %h", name, hdr_cnt, dst_mac, exp_dst);
    end
    checks++;
    if (got_q.size() !== len || count_diffs() !== 0) begin
      errors++; $display("[TB] FAIL %s payload: got %0d bytes %0d diffs want %0d bytes 0 diffs", name, got_q.size(), count_diffs(), len);
    end
    checks++;
    if (eof_at_q.size() !== exp_eof || sof_at_q.size() !== exp_eof) begin
      errors++; $display("[TB] FAIL %s sof_eof: got %0d/%0d want %0d/%0d", name, sof_at_q.size(), eof_at_q.size(), exp_eof, exp_eof);
    end else if (exp_eof == 1) begin
      checks++;
      if ({eof_len_q[0], eof_err_q[0], eof_fcs_q[0]} !== {len, exp_err, flip_bit < 0}) begin
        errors++; $display("[TB] FAIL %s status: got len %0d err %0d fcs %0d want %0d %0d %0d", name, eof_len_q[0], eof_err_q[0], eof_fcs_q[0], len, exp_err, flip_bit < 0);
      end
      checks++;
      if (sof_at_q[0] !== 0 || eof_at_q[0] !== len) begin
        errors++; $display("[TB] FAIL %s positions: got sof %0d eof %0d want 0 %0d", name, sof_at_q[0], eof_at_q[0], len);
      end
    end
  endtask

  task automatic test_frame_status();
    run_model_frame("bad_fcs", 46, 7, 1'b1, -1);
    run_model_frame("runt20", 20, 7, 1'b0, -1);
    run_model_frame("error_in", 46, 7, 1'b0, 10);
    run_model_frame("runt45", 45, 5, 1'b0, -1);
    run_model_frame("min46", 46, 5, 1'b0, -1);
    run_model_frame("one_byte", 1, 6, 1'b0, -1);
    run_model_frame("zero_byte", 0, 7, 1'b0, -1);
    run_model_frame("mtu", 1500, 7, 1'b0, -1);
    run_model_frame("oversize", 1501, 7, 1'b0, -1);
  endtask

  task automatic test_short_preamble();
    clear_mon();
    rand_hdr();
    rand_payload(46);
    build_frame(3, -1);
    exp_all.delete();
    drive_bytes(-1);
    idle(3);
    checks++;
    if (hdr_cnt !== 0 || got_q.size() !== 0 || eof_at_q.size() !== 0) begin
      errors++; $display("[TB] FAIL short_pre: got hdr %0d bytes %0d eof %0d want 0 0 0", hdr_cnt, got_q.size(), eof_at_q.size());
    end
    run_model_frame("after_short", 50, 5, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    int len1, len2;
    clear_mon();
    len1 = int'($urandom_range(46, 60));
    len2 = int'($urandom_range(46, 60));
    rand_hdr(); rand_payload(len1); build_frame(7, -1); drive_bytes(-1);
    rand_hdr(); rand_payload(len2); build_frame(7, -1); drive_bytes(-1);
    idle(3);
    checks++;
    if (hdr_cnt !== 2 || got_q.size() !== len1 + len2 || count_diffs() !== 0) begin
      errors++; $display("[TB] FAIL b2b_payload: got hdr %0d bytes %0d diffs %0d want 2 %0d 0", hdr_cnt, got_q.size(), count_diffs(), len1 + len2);
    end
    checks++;
    if (eof_at_q.size() !== 2 || sof_at_q.size() !== 2) begin
      errors++; $display("[TB] FAIL b2b_frames: got sof %0d eof %0d want 2 2", sof_at_q.size(), eof_at_q.size());
    end else begin
      checks++;
      if ({eof_at_q[0], eof_at_q[1], sof_at_q[1], eof_len_q[0], eof_len_q[1]} !== {len1, len1 + len2, len1, len1, len2}) begin
        errors++; $display("[TB] FAIL b2b_bounds: got eof %0d,%0d sof2 %0d len %0d,%0d want %0d,%0d %0d %0d,%0d", eof_at_q[0], eof_at_q[1], sof_at_q[1], eof_len_q[0], eof_len_q[1], len1, len1 + len2, len1, len1, len2);
      end
      checks++;
      if ({eof_err_q[0], eof_err_q[1], eof_fcs_q[0], eof_fcs_q[1]} !== 4'b0011) begin
        errors++; $display("[TB] FAIL b2b_status: got %b want 0011", {eof_err_q[0], eof_err_q[1], eof_fcs_q[0], eof_fcs_q[1]});
      end
    end
  endtask

  task automatic test_mid_reset();
    int rst_pos;
    clear_mon();
    rand_hdr();
    tx_pay.delete();
    for (int k = 0; k < 64; k++) tx_pay.push_back(8'(k));
    build_frame(7, -1);
    rst_pos = 8 + 14 + 30;
    for (int i = 0; i < wire_q.size(); i++) begin
      @(posedge clk); #1;
      data_in = wire_q[i]; valid_in = 1'b1; error_in = 1'b0;
      rst_n = (i != rst_pos);
      if (i == rst_pos + 1) begin
        clear_mon();
        @(negedge clk);
        checks++;
        if ({valid_out, sof_out, eof_out, error_out, fcs_ok, hdr_valid} !== 6'b0 || len_out !== 16'h0 || dst_mac !== 48'h0) begin
          errors++; $display("[TB] FAIL mid_reset_clear: got %b len %h dst %h want 0", {valid_out, sof_out, eof_out, error_out, fcs_ok, hdr_valid}, len_out, dst_mac);
        end
      end
    end
    @(posedge clk); #1;
    data_in = 8'h00; valid_in = 1'b0;
    idle(3);
    checks++;
    if (got_q.size() !== 0 || eof_at_q.size() !== 0 || hdr_cnt !== 0) begin
      errors++; $display("[TB] FAIL mid_reset_drop: got bytes %0d eof %0d hdr %0d want 0 0 0", got_q.size(), eof_at_q.size(), hdr_cnt);
    end
    run_model_frame("after_reset", 48, 7, 1'b0, -1);
  endtask

  task automatic test_random();
    int len, err_k;
    for (int n = 0; n < 10; n++) begin
      len   = int'($urandom_range(0, 90));
      err_k = (len > 0 && $urandom_range(4) == 0) ? int'($urandom_range(len - 1)) : -1;
      run_model_frame("random", len, int'($urandom_range(PRE_MIN, 12)), ($urandom_range(3) == 0), err_k);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_frame_status();
    test_short_preamble();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
